simple_apb_master: RTL and testbench
====================================

SIMPLE_APB_MASTER -- requirements
Module: simple_apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter WSTRB_WIDTH, default (DATA_WIDTH-1)/8+1, byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles without pready; 0 disables timeout.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock, all logic on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 cmd_valid  input  1  command request; cmd_ready  output  1  command accepted when both high.
REQ-008 cmd_write  input  1  1=write, 0=read; cmd_addr  input  ADDR_WIDTH  target address.
REQ-009 cmd_wdata  input  DATA_WIDTH  write data; cmd_strb  input  WSTRB_WIDTH  write byte strobes.
REQ-010 rsp_valid  output  1  response available; rsp_ready  input  1  response consumed when both high.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data; rsp_err  output  1  slave error or timeout.
REQ-012 m_psel, m_penable, m_pwrite  output  1 each  APB select, enable, direction.
REQ-013 m_paddr  output  ADDR_WIDTH; m_pwdata  output  DATA_WIDTH; m_pstrb  output  WSTRB_WIDTH.
REQ-014 m_prdata  input  DATA_WIDTH; m_pready  input  1; m_pslverr  input  1.

Function
REQ-015 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-016 cmd_ready SHALL be 1 only in IDLE; one transfer outstanding at a time.
REQ-017 IDLE: on cmd_valid&&cmd_ready, capture write/addr/wdata/strb, go SETUP next cycle.
REQ-018 SETUP (1 cycle): m_psel=1, m_penable=0, addr/pwrite/pwdata/pstrb driven from capture; go ACCESS.
REQ-019 ACCESS: m_psel=1, m_penable=1, all APB address/data/control held stable until exit.
REQ-020 ACCESS with m_pready=1: latch rsp_rdata=m_prdata for reads (0 for writes), rsp_err=m_pslverr, go RESP; m_psel/m_penable low next cycle.
REQ-021 m_pstrb SHALL be 0 for reads; m_pwdata SHALL be 0 outside SETUP/ACCESS of a write.
REQ-022 Timeout: counter clears on SETUP entry, increments each ACCESS cycle with m_pready=0; when TIMEOUT!=0 and count reaches TIMEOUT-1 with m_pready=0, exit to RESP with rsp_err=1, rsp_rdata=0.
REQ-023 m_pready=1 on the same cycle the timeout would fire SHALL take priority (normal completion).
REQ-024 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake go IDLE.
REQ-025 Zero-wait latency: cmd accepted cycle T -> SETUP T+1, ACCESS T+2, rsp_valid at T+3; next cmd_ready at cycle after rsp handshake.
REQ-026 m_pslverr SHALL be ignored except in ACCESS with m_pready=1.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE; m_psel, m_penable, m_pwrite, rsp_valid, rsp_err =0; m_paddr, m_pwdata, m_pstrb, rsp_rdata =0; timeout counter =0.
REQ-028 Reset mid-transfer SHALL abandon it with no response; cmd_ready=1 from first clock after rstn release.

Structure
REQ-029 FSM state enum and state width constant SHALL live in shared package simple_apb_pkg.
REQ-030 No sub-module required; timeout counter inline, width $clog2(TIMEOUT+1) (min 1).

Verification
REQ-031 Write addr=0x10, wdata=0xDEADBEEF, strb=0xF, pready=1 -> SETUP then ACCESS with those values, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-032 Read addr=0x24, slave returns 0x12345678 after 3 wait cycles -> psel/penable held 4 ACCESS cycles, rsp_rdata=0x12345678, m_pstrb=0.
REQ-033 Read with m_pslverr=1 on completing cycle -> rsp_err=1, rsp_rdata=m_prdata.
REQ-034 TIMEOUT=4, pready never high -> exactly 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; with TIMEOUT=0 ACCESS held 100+ cycles.
REQ-035 rsp_ready held low 5 cycles -> rsp_valid/data stable, cmd_ready=0 throughout; back-to-back cmds after handshake each complete correctly.
REQ-036 rstn asserted during ACCESS -> psel/penable/rsp_valid 0 immediately, no response emitted, next cmd completes normally.

Source files
------------

// File: rtl/simple_apb_pkg.sv
// -----------------------------------------------------------------------------
// simple_apb_pkg
// Shared definitions for the simple APB master: FSM state encoding, the state
// width constant and a helper that sizes the ACCESS-phase timeout counter.
// No ports (package).
// -----------------------------------------------------------------------------
package simple_apb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Width of a counter able to hold 0..timeout, never narrower than one bit.
    function automatic int tmo_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/simple_apb_master.sv
// -----------------------------------------------------------------------------
// simple_apb_master
// Converts a valid/ready command into one APB transfer (SETUP then ACCESS) and
// returns the result on a valid/ready response channel. One transfer is in
// flight at a time. An optional ACCESS timeout ends a stalled transfer with an
// error response.
//
// Ports
//   clk, rstn                       clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/addr/wdata/strb       command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              read data (0 on writes/timeouts), error flag
//   m_psel/m_penable/m_pwrite       APB control
//   m_paddr/m_pwdata/m_pstrb        APB address, write data, byte strobes
//   m_prdata/m_pready/m_pslverr     APB slave return signals
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module simple_apb_master
    import simple_apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WSTRB_WIDTH = (DATA_WIDTH - 1) / 8 + 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [WSTRB_WIDTH-1:0] cmd_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic                   m_psel,
    output logic                   m_penable,
    output logic                   m_pwrite,
    output logic [ADDR_WIDTH-1:0]  m_paddr,
    output logic [DATA_WIDTH-1:0]  m_pwdata,
    output logic [WSTRB_WIDTH-1:0] m_pstrb,
    input  logic [DATA_WIDTH-1:0]  m_prdata,
    input  logic                   m_pready,
    input  logic                   m_pslverr
);

    localparam int               CNT_W    = tmo_cnt_width(TIMEOUT);
    localparam bit               TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    apb_state_e       state_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             tmo_fire_s;

    // Timeout fires on the last permitted stalled ACCESS cycle; pready wins.
    assign tmo_fire_s = TMO_EN && (tmo_cnt_r == TMO_LAST);

    // Transfer FSM with all handshake and APB outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= {CNT_W{1'b0}};
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            rsp_err   <= 1'b0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= {ADDR_WIDTH{1'b0}};
            m_pwdata  <= {DATA_WIDTH{1'b0}};
            m_pstrb   <= {WSTRB_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // The APB registers double as the command capture.
                        state_r   <= ST_SETUP;
                        cmd_ready <= 1'b0;
                        tmo_cnt_r <= {CNT_W{1'b0}};
                        m_psel    <= 1'b1;
                        m_penable <= 1'b0;
                        m_pwrite  <= cmd_write;
                        m_paddr   <= cmd_addr;
                        m_pwdata  <= cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
                        m_pstrb   <= cmd_write ? cmd_strb : {WSTRB_WIDTH{1'b0}};
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    m_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (m_pready || tmo_fire_s) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        if (m_pready) begin
                            rsp_rdata <= m_pwrite ? {DATA_WIDTH{1'b0}} : m_prdata;
                            rsp_err   <= m_pslverr;
                        end else begin
                            rsp_rdata <= {DATA_WIDTH{1'b0}};
                            rsp_err   <= 1'b1;
                        end
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        m_pwrite  <= 1'b0;
                        m_paddr   <= {ADDR_WIDTH{1'b0}};
                        m_pwdata  <= {DATA_WIDTH{1'b0}};
                        m_pstrb   <= {WSTRB_WIDTH{1'b0}};
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    m_psel    <= 1'b0;
                    m_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_apb_master.sv
// -----------------------------------------------------------------------------
// tb_simple_apb_master
// Two masters share every input: dut uses TIMEOUT=4, dut_z disables the
// timeout. The bench plays the APB slave and the command/response agents.
// -----------------------------------------------------------------------------
module tb_simple_apb_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata, m_prdata;
    logic [3:0]  cmd_strb;
    logic        m_pready, m_pslverr;

    logic        cmd_ready, rsp_valid, rsp_err, m_psel, m_penable, m_pwrite;
    logic [31:0] rsp_rdata, m_paddr, m_pwdata;
    logic [3:0]  m_pstrb;

    logic        cmd_ready_z, rsp_valid_z, rsp_err_z, m_psel_z, m_penable_z, m_pwrite_z;
    logic [31:0] rsp_rdata_z, m_paddr_z, m_pwdata_z;
    logic [3:0]  m_pstrb_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simple_apb_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    simple_apb_master #(.TIMEOUT(0)) dut_z (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z),
        .m_psel(m_psel_z), .m_penable(m_penable_z), .m_pwrite(m_pwrite_z),
        .m_paddr(m_paddr_z), .m_pwdata(m_pwdata_z), .m_pstrb(m_pstrb_z),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer, entered and left on a falling edge with the
    // master idle. waits = pready-low ACCESS cycles before the slave answers.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic slverr,
                          input logic [31:0] rdata, input int rdelay);
        logic        tmo;
        int          acc;
        logic [31:0] exp_rd, exp_wd;
        logic [3:0]  exp_st;
        logic        exp_err;
        tmo     = (TMO != 0) && (waits >= TMO);
        acc     = tmo ? TMO : waits + 1;
        exp_rd  = (wr || tmo) ? 32'd0 : rdata;
        exp_err = tmo ? 1'b1 : slverr;
        exp_wd  = wr ? wdata : 32'd0;
        exp_st  = wr ? strb : 4'd0;

        chk("idle_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;

        @(negedge clk);
        // Keep offering junk commands while busy; none may be taken.
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        chk("setup_psel", m_psel, 1'b1);
        chk("setup_penable", m_penable, 1'b0);
        chk("setup_pwrite", m_pwrite, wr);
        chk("setup_paddr", m_paddr, addr);
        chk("setup_pwdata", m_pwdata, exp_wd);
        chk("setup_pstrb", m_pstrb, exp_st);
        chk("setup_cmd_ready", cmd_ready, 1'b0);
        chk("setup_rsp_valid", rsp_valid, 1'b0);
        m_pready = 1'b0; m_pslverr = 1'($urandom); m_prdata = $urandom;

        for (int n = 0; n < acc; n++) begin
            @(negedge clk);
            chk("acc_psel", m_psel, 1'b1);
            chk("acc_penable", m_penable, 1'b1);
            chk("acc_pwrite", m_pwrite, wr);
            chk("acc_paddr", m_paddr, addr);
            chk("acc_pwdata", m_pwdata, exp_wd);
            chk("acc_pstrb", m_pstrb, exp_st);
            chk("acc_rsp_valid", rsp_valid, 1'b0);
            chk("acc_cmd_ready", cmd_ready, 1'b0);
            m_pready  = (n == waits);
            m_prdata  = (n == waits) ? rdata : $urandom;
            m_pslverr = (n == waits) ? slverr : 1'($urandom);
        end

        for (int d = 0; d <= rdelay; d++) begin
            @(negedge clk);
            m_pready = 1'b0; m_pslverr = 1'($urandom); m_prdata = $urandom;
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_psel", m_psel, 1'b0);
            chk("rsp_penable", m_penable, 1'b0);
            chk("rsp_pwdata", m_pwdata, 32'd0);
            chk("rsp_pstrb", m_pstrb, 4'd0);
            chk("rsp_cmd_ready", cmd_ready, 1'b0);
            if (d == 0 && !tmo) begin
                chk("z_rsp_valid", rsp_valid_z, 1'b1);
                chk("z_rsp_rdata", rsp_rdata_z, exp_rd);
                chk("z_rsp_err", rsp_err_z, exp_err);
            end
            rsp_ready = (d == rdelay);
        end

        @(negedge clk);
        rsp_ready = 1'b0; cmd_valid = 1'b0; m_pslverr = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        cmd_strb = 4'd0; rsp_ready = 1'b0; m_prdata = 32'd0; m_pready = 1'b0; m_pslverr = 1'b0;

        // Reset values
        #12;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_psel", m_psel, 1'b0);
        chk("rst_penable", m_penable, 1'b0);
        chk("rst_pwrite", m_pwrite, 1'b0);
        chk("rst_paddr", m_paddr, 32'd0);
        chk("rst_pwdata", m_pwdata, 32'd0);
        chk("rst_pstrb", m_pstrb, 4'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Directed: zero-wait write, read with 3 waits, read with slave error,
        // write with a slow response consumer.
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0BADF00D, 0);
        do_txn(1'b0, 32'h24, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0);
        do_txn(1'b0, 32'h30, 32'h0, 4'h3, 1, 1'b1, 32'hCAFE0001, 1);
        do_txn(1'b1, 32'h44, 32'h55AA55AA, 4'h5, 2, 1'b0, 32'h0, 5);

        // Randomized back-to-back transfers within the timeout budget
        for (int i = 0; i < 12; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, TMO - 1)),
                   1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        // Stalled slave: dut times out, dut_z keeps waiting.
        do_txn(1'b0, 32'h88, 32'h0, 4'hF, 1000, 1'b0, 32'h0, 2);
        for (int i = 0; i < 110; i++) begin
            chk("z_hold_psel", m_psel_z, 1'b1);
            chk("z_hold_penable", m_penable_z, 1'b1);
            chk("z_hold_rsp_valid", rsp_valid_z, 1'b0);
            @(negedge clk);
        end
        m_pready = 1'b1; m_prdata = 32'hA5A50F0F; m_pslverr = 1'b0;
        @(negedge clk);
        m_pready = 1'b0;
        chk("z_done_rsp_valid", rsp_valid_z, 1'b1);
        chk("z_done_rsp_rdata", rsp_rdata_z, 32'hA5A50F0F);
        chk("z_done_rsp_err", rsp_err_z, 1'b0);
        chk("z_done_psel", m_psel_z, 1'b0);
        chk("idle_psel_unaffected", m_psel, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("z_post_rsp_valid", rsp_valid_z, 1'b0);
        chk("z_post_cmd_ready", cmd_ready_z, 1'b1);

        // Reset in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5C; cmd_wdata = 32'h01020304; cmd_strb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0; m_pready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_penable", m_penable, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_psel", m_psel, 1'b0);
        chk("mid_rst_penable", m_penable, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_paddr", m_paddr, 32'd0);
        chk("mid_rst_pwdata", m_pwdata, 32'd0);
        chk("mid_rst_z_psel", m_psel_z, 1'b0);
        @(negedge clk);
        rstn = 1'b1; m_pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_cmd_ready", cmd_ready, 1'b1);
            chk("post_rst_rsp_valid", rsp_valid, 1'b0);
            chk("post_rst_psel", m_psel, 1'b0);
        end
        m_pready = 1'b0;
        do_txn(1'b0, 32'h60, 32'h0, 4'hF, 1, 1'b0, 32'h600DCAFE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
